// File: rtl/dispsel_ctrl.sv
// Display-selection controller: synchronizes and debounces the next/prev keys and the
// auto-rotate switch, and steps the 7-entry display selection on key presses or a timer.
module dispsel_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned AUTO_CYCLES     = 100000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_next_n,
    input  logic       key_prev_n,
    input  logic       auto_en,
    output logic [2:0] sel,
    output logic       sel_changed
);

    localparam int unsigned DW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned AW = (AUTO_CYCLES > 2) ? $clog2(AUTO_CYCLES) : 1;
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [AW-1:0] AUTO_LAST = AW'(AUTO_CYCLES - 1);

    typedef enum logic [2:0] {
        CC    = 3'd0,
        PC    = 3'd1,
        INSTR = 3'd2,
        X     = 3'd3,
        OP    = 3'd4,
        STATE = 3'd5,
        ADDR  = 3'd6
    } dispsel_t;

    // Index 0 = next key, index 1 = prev key.
    logic [1:0]    key_m;
    logic [1:0]    key_s;
    logic [1:0]    stable;
    logic [1:0]    ev;
    logic [DW-1:0] deb_cnt [2];
    logic          auto_m;
    logic          auto_s;
    logic [AW-1:0] auto_cnt;
    dispsel_t      sel_q;
    logic          auto_tick_c;

    function automatic dispsel_t sel_next(input dispsel_t s);
        case (s)
            CC:      sel_next = PC;
            PC:      sel_next = INSTR;
            INSTR:   sel_next = X;
            X:       sel_next = OP;
            OP:      sel_next = STATE;
            STATE:   sel_next = ADDR;
            default: sel_next = CC;
        endcase
    endfunction

    function automatic dispsel_t sel_prev(input dispsel_t s);
        case (s)
            CC:      sel_prev = ADDR;
            ADDR:    sel_prev = STATE;
            STATE:   sel_prev = OP;
            OP:      sel_prev = X;
            X:       sel_prev = INSTR;
            INSTR:   sel_prev = PC;
            default: sel_prev = CC;
        endcase
    endfunction

    assign auto_tick_c = auto_s && (auto_cnt == AUTO_LAST);
    assign sel         = sel_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            key_m       <= 2'b11;
            key_s       <= 2'b11;
            stable      <= 2'b11;
            ev          <= 2'b00;
            deb_cnt[0]  <= '0;
            deb_cnt[1]  <= '0;
            auto_m      <= 1'b0;
            auto_s      <= 1'b0;
            auto_cnt    <= '0;
            sel_q       <= CC;
            sel_changed <= 1'b0;
        end else begin
            key_m  <= {key_prev_n, key_next_n};
            key_s  <= key_m;
            auto_m <= auto_en;
            auto_s <= auto_m;

            // Debounce: accept a new level only after DEBOUNCE_CYCLES disagreeing cycles.
            for (int i = 0; i < 2; i++) begin
                ev[i] <= 1'b0;
                if (key_s[i] == stable[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_LAST) begin
                    stable[i]  <= key_s[i];
                    deb_cnt[i] <= '0;
                    ev[i]      <= ~key_s[i];
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + DW'(1);
                end
            end

            if ((|ev) || !auto_s || auto_tick_c) begin
                auto_cnt <= '0;
            end else begin
                auto_cnt <= auto_cnt + AW'(1);
            end

            // Key events take priority over the auto tick; both keys together cancel.
            case (ev)
                2'b01: begin
                    sel_q       <= sel_next(sel_q);
                    sel_changed <= 1'b1;
                end
                2'b10: begin
                    sel_q       <= sel_prev(sel_q);
                    sel_changed <= 1'b1;
                end
                2'b11: begin
                    sel_changed <= 1'b0;
                end
                default: begin
                    if (auto_tick_c) begin
                        sel_q       <= sel_next(sel_q);
                        sel_changed <= 1'b1;
                    end else begin
                        sel_changed <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dispsel_ctrl.sv
// Directed and random-stimulus bench for dispsel_ctrl with DEBOUNCE_CYCLES=4, AUTO_CYCLES=16.
module tb_dispsel_ctrl;

    localparam logic [2:0] CC    = 3'd0;
    localparam logic [2:0] PC    = 3'd1;
    localparam logic [2:0] INSTR = 3'd2;
    localparam logic [2:0] X     = 3'd3;
    localparam logic [2:0] OP    = 3'd4;
    localparam logic [2:0] STATE = 3'd5;
    localparam logic [2:0] ADDR  = 3'd6;

    logic       clk = 1'b0;
    logic       reset;
    logic       key_next_n;
    logic       key_prev_n;
    logic       auto_en;
    logic [2:0] sel;
    logic       sel_changed;

    int n_checks = 0;
    int n_fail   = 0;

    dispsel_ctrl #(.DEBOUNCE_CYCLES(4), .AUTO_CYCLES(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .key_next_n  (key_next_n),
        .key_prev_n  (key_prev_n),
        .auto_en     (auto_en),
        .sel         (sel),
        .sel_changed (sel_changed)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] m_next(input logic [2:0] s);
        return (s == ADDR) ? CC : 3'(s + 3'd1);
    endfunction

    function automatic logic [2:0] m_prev(input logic [2:0] s);
        return (s == CC) ? ADDR : 3'(s - 3'd1);
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic step_count(input int n, output int pulses);
        pulses = 0;
        repeat (n) begin
            @(posedge clk);
            #1;
            if (sel_changed === 1'b1) pulses++;
        end
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        key_next_n = 1'b1;
        key_prev_n = 1'b1;
        auto_en    = 1'b0;
        step(2);
        reset = 1'b0;
    endtask

    task automatic press(input logic nxt, input logic prv, output int pulses);
        int p;
        key_next_n = ~nxt;
        key_prev_n = ~prv;
        step_count(12, p);
        pulses = p;
        key_next_n = 1'b1;
        key_prev_n = 1'b1;
        step_count(10, p);
        pulses += p;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (sel !== CC) begin
            n_fail++;
            $display("FAIL reset_sel: got %0d want %0d", sel, CC);
        end
        n_checks++;
        if (sel_changed !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_changed: got %b want 0", sel_changed);
        end
        step(10);
        n_checks++;
        if (sel !== CC) begin
            n_fail++;
            $display("FAIL idle_sel: got %0d want %0d", sel, CC);
        end
    endtask

    task automatic test_hold_next();
        int p;
        do_reset();
        key_next_n = 1'b0;
        step(6);
        n_checks++;
        if (sel !== CC) begin
            n_fail++;
            $display("FAIL hold_early: got %0d want %0d", sel, CC);
        end
        step(1);
        n_checks++;
        if (sel !== PC || sel_changed !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_step: got sel=%0d chg=%b want sel=%0d chg=1", sel, sel_changed, PC);
        end
        step_count(50, p);
        n_checks++;
        if (p != 0 || sel !== PC) begin
            n_fail++;
            $display("FAIL hold_repeat: got sel=%0d pulses=%0d want sel=%0d pulses=0", sel, p, PC);
        end
        key_next_n = 1'b1;
        step(10);
    endtask

    task automatic test_bounce();
        int p;
        int total = 0;
        do_reset();
        repeat (10) begin
            key_next_n = 1'b0;
            step_count(3, p);
            total += p;
            key_next_n = 1'b1;
            step_count(3, p);
            total += p;
        end
        step_count(10, p);
        total += p;
        n_checks++;
        if (sel !== CC || total != 0) begin
            n_fail++;
            $display("FAIL bounce: got sel=%0d pulses=%0d want sel=%0d pulses=0", sel, total, CC);
        end
    endtask

    task automatic test_wrap();
        int p;
        logic [2:0] exp_seq [7];
        exp_seq = '{CC, PC, INSTR, X, OP, STATE, ADDR};
        do_reset();
        press(1'b0, 1'b1, p);
        n_checks++;
        if (sel !== ADDR || p != 1) begin
            n_fail++;
            $display("FAIL prev_wrap: got sel=%0d pulses=%0d want sel=%0d pulses=1", sel, p, ADDR);
        end
        for (int i = 0; i < 7; i++) begin
            press(1'b1, 1'b0, p);
            n_checks++;
            if (sel !== exp_seq[i] || p != 1) begin
                n_fail++;
                $display("FAIL next_seq[%0d]: got sel=%0d pulses=%0d want sel=%0d pulses=1",
                         i, sel, p, exp_seq[i]);
            end
        end
        press(1'b1, 1'b1, p);
        n_checks++;
        if (sel !== ADDR || p != 0) begin
            n_fail++;
            $display("FAIL both_keys: got sel=%0d pulses=%0d want sel=%0d pulses=0", sel, p, ADDR);
        end
    endtask

    task automatic test_auto();
        int p;
        do_reset();
        auto_en = 1'b1;
        step(17);
        n_checks++;
        if (sel !== CC) begin
            n_fail++;
            $display("FAIL auto_early: got %0d want %0d", sel, CC);
        end
        step(1);
        n_checks++;
        if (sel !== PC || sel_changed !== 1'b1) begin
            n_fail++;
            $display("FAIL auto_first: got sel=%0d chg=%b want sel=%0d chg=1", sel, sel_changed, PC);
        end
        for (int k = 2; k <= 7; k++) begin
            step_count(15, p);
            n_checks++;
            if (p != 0 || sel !== 3'(k - 1)) begin
                n_fail++;
                $display("FAIL auto_hold[%0d]: got sel=%0d pulses=%0d want sel=%0d pulses=0",
                         k, sel, p, k - 1);
            end
            step(1);
            n_checks++;
            if (sel !== 3'(k % 7) || sel_changed !== 1'b1) begin
                n_fail++;
                $display("FAIL auto_tick[%0d]: got sel=%0d chg=%b want sel=%0d chg=1",
                         k, sel, sel_changed, k % 7);
            end
        end
        // Time a next press so its event lands on the following tick edge.
        step(9);
        key_next_n = 1'b0;
        step(6);
        n_checks++;
        if (sel !== CC) begin
            n_fail++;
            $display("FAIL coinc_early: got %0d want %0d", sel, CC);
        end
        step(1);
        n_checks++;
        if (sel !== PC || sel_changed !== 1'b1) begin
            n_fail++;
            $display("FAIL coinc_step: got sel=%0d chg=%b want sel=%0d chg=1", sel, sel_changed, PC);
        end
        key_next_n = 1'b1;
        step_count(15, p);
        n_checks++;
        if (p != 0 || sel !== PC) begin
            n_fail++;
            $display("FAIL coinc_hold: got sel=%0d pulses=%0d want sel=%0d pulses=0", sel, p, PC);
        end
        step(1);
        n_checks++;
        if (sel !== INSTR || sel_changed !== 1'b1) begin
            n_fail++;
            $display("FAIL coinc_next_tick: got sel=%0d chg=%b want sel=%0d chg=1", sel, sel_changed, INSTR);
        end
        auto_en = 1'b0;
        step_count(40, p);
        n_checks++;
        if (p != 0 || sel !== INSTR) begin
            n_fail++;
            $display("FAIL auto_off: got sel=%0d pulses=%0d want sel=%0d pulses=0", sel, p, INSTR);
        end
    endtask

    task automatic test_reset_mid();
        int p;
        do_reset();
        press(1'b1, 1'b0, p);
        n_checks++;
        if (sel !== PC) begin
            n_fail++;
            $display("FAIL mid_setup: got %0d want %0d", sel, PC);
        end
        key_next_n = 1'b0;
        step(4);
        reset = 1'b1;
        step(1);
        n_checks++;
        if (sel !== CC || sel_changed !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: got sel=%0d chg=%b want sel=%0d chg=0", sel, sel_changed, CC);
        end
        reset = 1'b0;
        // Synchronizers restart at released, so the held key re-enters through them.
        step(6);
        n_checks++;
        if (sel !== CC) begin
            n_fail++;
            $display("FAIL mid_early: got %0d want %0d", sel, CC);
        end
        step(1);
        n_checks++;
        if (sel !== PC || sel_changed !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_press: got sel=%0d chg=%b want sel=%0d chg=1", sel, sel_changed, PC);
        end
        key_next_n = 1'b1;
        step(10);
    endtask

    task automatic test_random();
        logic [2:0] prev_sel;
        int changes = 0;
        int cyc = 0;
        int dur;
        do_reset();
        prev_sel = sel;
        while (cyc < 50000) begin
            key_next_n = 1'($urandom_range(0, 1));
            key_prev_n = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0) auto_en = ~auto_en;
            dur = $urandom_range(1, 12);
            repeat (dur) begin
                step(1);
                cyc++;
                n_checks++;
                if (sel > ADDR) begin
                    n_fail++;
                    $display("FAIL rnd_legal: got sel=%0d at cycle %0d", sel, cyc);
                end
                n_checks++;
                if (sel !== prev_sel) begin
                    changes++;
                    if (sel_changed !== 1'b1 || (sel !== m_next(prev_sel) && sel !== m_prev(prev_sel))) begin
                        n_fail++;
                        $display("FAIL rnd_change: got %0d->%0d chg=%b want one step with chg=1 at cycle %0d",
                                 prev_sel, sel, sel_changed, cyc);
                    end
                end else if (sel_changed !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rnd_pulse: got chg=%b with sel steady at %0d want 0 at cycle %0d",
                             sel_changed, sel, cyc);
                end
                prev_sel = sel;
            end
        end
        n_checks++;
        if (changes == 0) begin
            n_fail++;
            $display("FAIL rnd_activity: got %0d changes want >0", changes);
        end
    endtask

    initial begin
        reset      = 1'b1;
        key_next_n = 1'b1;
        key_prev_n = 1'b1;
        auto_en    = 1'b0;
        test_reset();
        test_hold_next();
        test_bounce();
        test_wrap();
        test_auto();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
